// File: rtl/cellram_pkg.sv
// Purpose : shared types and constants for the cell RAM bus responder.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package cellram_pkg;

    localparam int CELLRAM_ADDR_WIDTH  = 23;
    localparam int CELLRAM_DATA_WIDTH  = 16;
    localparam int CELLRAM_MIN_LATENCY = 2;
    // Wide enough for the largest legal READ_LATENCY (15).
    localparam int CELLRAM_LAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WRITE_BURST = 2'd1,
        ST_READ_LAT    = 2'd2,
        ST_READ_BURST  = 2'd3
    } cellram_state_e;

endpackage

// File: rtl/cellram_storage.sv
// Purpose : single-port synchronous RAM, 2^DEPTH_LOG2 x DATA_WIDTH, registered read data.
// Latency : write takes effect on the edge; dout_o shows mem[addr_i] one edge after addr_i.
// Backpressure : none; a read is performed every cycle (read-before-write on the same address).
// Ports   : clk, we_i (write strobe), addr_i (word address), din_i (write data),
//           dout_o (registered read data, holds mem[addr] from the previous cycle).
module cellram_storage #(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] dout_q;

    // Storage is deliberately never reset so contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= din_i;
        end
        dout_q <= mem_q[addr_i];
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/cellram_responder.sv
// Purpose : cell RAM bus responder; burst writes and latency-delayed burst reads on on-chip storage.
// Latency : writes zero-cycle; first read word READ_LATENCY cycles after the address cycle, then one per cycle.
// Backpressure : mem_oe low during a read burst pauses it (bus released, pointer and word held).
// Ports   : clk, reset (sync, active-high), mem_addr/mem_addr_valid (burst start),
//           mem_data (bidirectional data), mem_we/mem_oe (write / read advance),
//           mem_wait (read data not yet valid), burst_active, conflict (sticky we&oe).
module cellram_responder
    import cellram_pkg::*;
#(
    parameter int ADDR_WIDTH   = CELLRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = CELLRAM_DATA_WIDTH,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_we,
    input  logic                  mem_oe,
    input  logic                  mem_addr_valid,
    output logic                  mem_wait,
    output logic                  burst_active,
    output logic                  conflict
);

    localparam logic [CELLRAM_LAT_CNT_W-1:0] LAT_LOAD = CELLRAM_LAT_CNT_W'(READ_LATENCY - 1);
    localparam logic [CELLRAM_LAT_CNT_W-1:0] LAT_LAST = CELLRAM_LAT_CNT_W'(1);

    cellram_state_e               state_q, state_d;
    logic [DEPTH_LOG2-1:0]        ptr_q, ptr_d;
    logic [CELLRAM_LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic                         conflict_q, conflict_d;

    logic                         ram_we;
    logic [DEPTH_LOG2-1:0]        ram_addr;
    logic [DATA_WIDTH-1:0]        ram_dout;
    logic [DEPTH_LOG2-1:0]        start_addr;
    logic                         rd_advance;

    // Upper address bits alias onto the storage and are intentionally dropped.
    logic                         unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];

    assign start_addr = mem_addr[DEPTH_LOG2-1:0];

    // A word is handed out only when the bus is actually driven; a we&oe
    // collision in a read burst therefore behaves like a pause.
    assign rd_advance = (state_q == ST_READ_BURST) && mem_oe && !mem_we;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ram_we     = 1'b0;
        ram_addr   = ptr_q;
        conflict_d = conflict_q | (mem_we & mem_oe);

        if (mem_addr_valid) begin
            // A new address aborts whatever burst is in flight.
            if (mem_we) begin
                ram_we   = 1'b1;
                ram_addr = start_addr;
                ptr_d    = start_addr + 1'b1;
                state_d  = ST_WRITE_BURST;
            end else begin
                ptr_d    = start_addr;
                cnt_d    = LAT_LOAD;
                state_d  = ST_READ_LAT;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_WRITE_BURST: begin
                    if (mem_we) begin
                        ram_we = 1'b1;
                        ptr_d  = ptr_q + 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ_LAT: begin
                    // The RAM reads ptr every latency cycle; the read issued in
                    // the last one lands in the output register on burst entry.
                    if (cnt_q <= LAT_LAST) begin
                        state_d = ST_READ_BURST;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_READ_BURST: begin
                    // Prefetch the next word when advancing; otherwise re-read
                    // ptr so the output register keeps the paused word.
                    if (rd_advance) begin
                        ptr_d    = ptr_q + 1'b1;
                        ram_addr = ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    cellram_storage #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_storage (
        .clk    (clk),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .din_i  (mem_data),
        .dout_o (ram_dout)
    );

    assign mem_data     = rd_advance ? ram_dout : {DATA_WIDTH{1'bz}};
    assign mem_wait     = (state_q == ST_READ_LAT);
    assign burst_active = (state_q == ST_WRITE_BURST) || (state_q == ST_READ_BURST);
    assign conflict     = conflict_q;

endmodule

// File: doc/cellram_responder.md
# cellram_responder

Behavioural-synthesizable responder for the 16-bit cell RAM bus driven by the memory arbitrator. It decodes `mem_addr_valid`/`mem_we`/`mem_oe` into burst writes and latency-delayed burst reads against on-chip storage. It drives `mem_data` only during read bursts. It replaces the plain BRAM stand-in on the arbitrator's memory port in cosim and on boards without external cell RAM.

## Interface
- `ADDR_WIDTH`, 23: bus address width (word address).
- `DATA_WIDTH`, 16: bus data width.
- `DEPTH_LOG2`, 12: storage depth is 2^DEPTH_LOG2 words. Address bits above DEPTH_LOG2-1 are ignored, so the storage aliases.
- `READ_LATENCY`, 3: cycles from the address cycle to the first read word. Legal range is 2..15.

Ports:
- `clk` in 1: memory clock, driven from the arbitrator's `mem_clk`. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `mem_addr` in ADDR_WIDTH: burst start address, sampled only when `mem_addr_valid` = 1.
- `mem_data` inout DATA_WIDTH: write data in, read data out. High-Z whenever not driving.
- `mem_we` in 1: write enable, active-high.
- `mem_oe` in 1: output enable / read advance, active-high.
- `mem_addr_valid` in 1: starts a new burst.
- `mem_wait` out 1: high while read data is not yet valid.
- `burst_active` out 1: high in WRITE_BURST and READ_BURST.
- `conflict` out 1: sticky flag, set when `mem_we` and `mem_oe` are high together. Cleared only by reset.

## Operation
- States: IDLE, WRITE_BURST, READ_LAT, READ_BURST. A burst pointer `ptr` is DEPTH_LOG2 bits wide.
- `mem_addr_valid` = 1 in any state starts a new burst and aborts any burst in progress:
  - Load `ptr` from `mem_addr[DEPTH_LOG2-1:0]`.
  - If `mem_we` = 1: write `mem_data` to the start address in the same cycle, set `ptr` to start + 1, go to WRITE_BURST.
  - If `mem_we` = 0: go to READ_LAT and load the latency counter with READ_LATENCY-1.
- WRITE_BURST:
  - Each cycle with `mem_we` = 1 writes `mem_data` to `ptr`, then increments `ptr`.
  - `mem_we` = 0 returns to IDLE.
- READ_LAT:
  - `mem_wait` = 1. The counter decrements each cycle.
  - At 0, go to READ_BURST. The storage read of `ptr` is issued one cycle earlier so the output register is valid on entry.
- READ_BURST:
  - `mem_wait` = 0.
  - If `mem_oe` = 1: drive the registered word for `ptr` and advance `ptr`.
  - If `mem_oe` = 0: release the bus, hold `ptr`, and keep the current word (pause). The next `mem_oe` = 1 presents the same word.
  - Runs until a new `mem_addr_valid` or reset. There is no length limit.
- `ptr` increments modulo 2^DEPTH_LOG2, so 2^DEPTH_LOG2-1 wraps to 0.
- `mem_we` and `mem_oe` both high: the write is performed, the bus is not driven, and `conflict` is set.
- `mem_we` = 1 during READ_LAT or READ_BURST without `mem_addr_valid`: ignored, nothing is written, and `conflict` is not set unless `mem_oe` = 1.
- Reset, including mid-burst:
  - State goes to IDLE, `ptr` to 0, the bus is released.
  - `mem_wait`, `burst_active` and `conflict` go to 0.
  - Storage contents are preserved.

## Timing
- Reset values: `mem_data` = Z, `mem_wait` = 0, `burst_active` = 0, `conflict` = 0.
- Write: data is sampled on the same edge as the address. One word per cycle, zero-cycle latency.
- Read: with address at cycle 0, `mem_wait` is high on cycles 1..READ_LATENCY-1. `mem[start]` is valid on cycle READ_LATENCY if `mem_oe` = 1, followed by one word per cycle.
- `mem_data` output enable = `state == READ_BURST && mem_oe && !mem_we`. Data is registered; the enable is combinational from inputs.
- The abort/restart from a new `mem_addr_valid` takes effect on the next edge. A new read restarts the full latency.

## Structure
- Package `cellram_pkg`: state enum, `CELLRAM_ADDR_WIDTH` = 23, `CELLRAM_DATA_WIDTH` = 16, `CELLRAM_MIN_LATENCY` = 2.
- Sub-module `cellram_storage`: single-port synchronous RAM (we, addr, din, registered dout), 2^DEPTH_LOG2 × DATA_WIDTH.
- The top level holds the FSM, `ptr`, the latency counter, tri-state control and the flags.

## Test plan
- Reset then idle: `mem_data` = Z, `mem_wait` = 0, `conflict` = 0 for 10 cycles.
- Write burst of 0x1111, 0x2222, 0x3333 at address 0x10, then read at 0x10 with READ_LATENCY = 3: `mem_wait` high on cycles 1–2; 0x1111, 0x2222, 0x3333 on cycles 3–5.
- Write 0xAAAA, 0xBBBB at address 2^12-1 (wraps), then read at address 0x1000 (alias of 0): reads 0xBBBB first.
- Read burst with `mem_oe` dropped for 2 cycles mid-burst: bus is Z for those cycles, then resumes with the next unread word and no skip.
- New `mem_addr_valid` (read at 0x20) during a read burst at 0x10: latency restarts, and the first word is `mem[0x20]`.
- `mem_we` = `mem_oe` = 1 in WRITE_BURST: word is written, bus not driven, `conflict` = 1 and stays set until reset. Reset mid-READ_LAT leaves storage intact, verified by a subsequent read.
